wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the pipeline writeback stage and a long-latency multiply/divide unit (MDU). The block sits beside the M/W pipeline register. Pipeline writes have priority. An MDU result that loses arbitration is parked in a one-entry pending buffer. If it waits too long, the arbiter stalls the W stage for one cycle to guarantee it is written. The pending destination is exported so the hazard unit can detect RAW dependencies against the parked result.

## Interface
- XLEN, 32, data width
- MAX_WAIT, 4, max cycles a parked result may lose arbitration before a forced stall; legal range ≥1

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- regwritew  in  1  W-stage write request
- rdw  in  5  W-stage destination
- resultw  in  XLEN  W-stage write data
- mdu_valid  in  1  MDU result valid
- mdu_rd  in  5  MDU destination
- mdu_result  in  XLEN  MDU write data
- mdu_ready  out  1  arbiter can accept an MDU result this cycle
- rf_we  out  1  register-file write enable
- rf_a3  out  5  register-file write address
- rf_wd  out  XLEN  register-file write data
- stallw  out  1  freezes the M/W register and all upstream stages
- pend_valid  out  1  pending buffer occupied
- pend_rd  out  5  pending buffer destination

## Operation
- Request definitions:
  - Pipeline request: regwritew=1 and rdw≠0.
  - rd=0 is never a request.
- MDU handshake:
  - An MDU result is accepted when mdu_valid && mdu_ready.
  - An accepted result with mdu_rd=0 is discarded.
- FSM states: IDLE (buffer empty), HELD (buffer full, counting), FORCE (buffer full, stall asserted).
- IDLE:
  - mdu_ready=1.
  - Pipeline request present: the pipeline is granted the port. A simultaneously accepted MDU result (mdu_rd≠0) is captured into the buffer; wait_cnt←0; next state HELD.
  - No pipeline request: an accepted MDU result is written straight through (bypass); state stays IDLE.
- HELD:
  - mdu_ready=0.
  - No pipeline request: the buffer is written to the register file; next state IDLE.
  - Pipeline request with rdw==pend_rd: the pipeline write wins and the buffer is dropped, since the younger write supersedes the parked one. Next state IDLE.
  - Other pipeline request with wait_cnt==MAX_WAIT-1: the pipeline is granted; next state FORCE.
  - Other pipeline request, otherwise: the pipeline is granted; wait_cnt+1.
- FORCE:
  - stallw=1 and mdu_ready=0.
  - The buffer is written; the pipeline write is suppressed this cycle.
  - Next state IDLE. The frozen W instruction re-presents and writes in the following cycle.
- Port output values:
  - pend_valid=1 in HELD and FORCE; pend_rd = buffer rd, or 0 when empty.
  - rf_a3 and rf_wd are 0 whenever rf_we=0.
- wait_cnt width is clog2(MAX_WAIT+1) and never wraps. It is cleared on every entry to HELD.

## Timing
- rf_we, rf_a3, rf_wd, stallw and mdu_ready are combinational from the current inputs and the registered state. The register file samples them on the same clk edge.
- Write latency:
  - Bypass: 0 cycles.
  - Parked result: at most MAX_WAIT+1 cycles after acceptance.
- Worst-case cost to the pipeline: one stall cycle per parked result.
- Reset (reset_n=0, asynchronous, at any time, including HELD or FORCE):
  - state←IDLE, buffer cleared, wait_cnt←0.
  - All outputs held at 0 while reset_n=0, including mdu_ready.
  - A parked result is lost.
- The first MDU acceptance is possible on the first rising edge after reset_n deasserts.

## Structure
- The shared package riscv_pkg holds the XLEN default, REG_ADDR_W=5 and the arb_state_t enum {IDLE, HELD, FORCE}.
- One sub-module, wb_pend_buf:
  - Holds the one-entry rd/data register with load and clear.
  - Exposes valid/rd/data.
- The FSM, wait counter and output mux stay in wb_port_arbiter.

## Test plan
- Bypass: IDLE, regwritew=0, mdu_valid=1, mdu_rd=7, mdu_result=0x1234 -> same cycle rf_we=1, rf_a3=7, rf_wd=0x1234; state stays IDLE.
- Park and drain: regwritew=1 (rdw=3) while MDU valid (rd=9, 0xAA) -> rf_a3=3 and pend_valid=1, pend_rd=9. Next cycle regwritew=0 -> rf_a3=9, rf_wd=0xAA; state IDLE.
- Forced stall, MAX_WAIT=4: park rd=9, then regwritew=1 with rdw≠9 for 4 consecutive cycles -> FORCE entered, stallw=1 for exactly one cycle with rf_a3=9. Next cycle stallw=0 and the pipeline write proceeds.
- WAW drop: HELD with pend_rd=5, pipeline writes rdw=5 data 0x77 -> rf_wd=0x77, buffer cleared, pend_valid=0; the parked value is never written.
- x0 handling: mdu_rd=0 accepted in IDLE -> rf_we=0, no state change. regwritew=1 with rdw=0 -> treated as no request, so a parked result drains.
- Reset in FORCE: drop reset_n mid-cycle -> all outputs 0 immediately; after release state is IDLE, pend_valid=0, mdu_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the register-file write-port
//               arbiter (data width default, register address width, FSM
//               state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ADDR_W   = 5;

    // IDLE: buffer empty; HELD: result parked and aging; FORCE: stall W to drain
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of the W-stage request, MDU handshake, register-file
//               write port and hazard-export signals around the arbiter.
//               master = pipeline/MDU side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN_DEFAULT
);
    // W-stage write request
    logic                                regwritew;
    logic [riscv_pkg::REG_ADDR_W-1:0]    rdw;
    logic [XLEN-1:0]                     resultw;
    // MDU result handshake
    logic                                mdu_valid;
    logic [riscv_pkg::REG_ADDR_W-1:0]    mdu_rd;
    logic [XLEN-1:0]                     mdu_result;
    logic                                mdu_ready;
    // Register-file write port
    logic                                rf_we;
    logic [riscv_pkg::REG_ADDR_W-1:0]    rf_a3;
    logic [XLEN-1:0]                     rf_wd;
    // Pipeline control and hazard export
    logic                                stallw;
    logic                                pend_valid;
    logic [riscv_pkg::REG_ADDR_W-1:0]    pend_rd;

    modport master (
        output regwritew, rdw, resultw, mdu_valid, mdu_rd, mdu_result,
        input  mdu_ready, rf_we, rf_a3, rf_wd, stallw, pend_valid, pend_rd
    );

    modport slave (
        input  regwritew, rdw, resultw, mdu_valid, mdu_rd, mdu_result,
        output mdu_ready, rf_we, rf_a3, rf_wd, stallw, pend_valid, pend_rd
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_pend_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_pend_buf
// Description : One-entry parking register for an MDU result that lost the
//               write port. Load captures rd/data, clear empties it; rd/data
//               read back as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_pend_buf
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  wire logic                  clk,
    input  wire logic                  reset_n,
    input  wire logic                  load,
    input  wire logic                  clear,
    input  wire logic [REG_ADDR_W-1:0] load_rd,
    input  wire logic [XLEN-1:0]       load_data,
    output logic                       valid,
    output logic [REG_ADDR_W-1:0]      rd,
    output logic [XLEN-1:0]            data
);

    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rd_q,    rd_d;
    logic [XLEN-1:0]       data_q,  data_d;

    // Next-entry selection; load and clear are never requested together
    always_comb begin
        valid_d = valid_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            rd_d    = '0;
            data_d  = '0;
        end
        if (load) begin
            valid_d = 1'b1;
            rd_d    = load_rd;
            data_d  = load_data;
        end
    end

    // Entry storage; reset empties the buffer and drops any parked result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign rd    = rd_q;
    assign data  = data_q;

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the register-file write port between the W stage
//               (priority) and the MDU. A losing MDU result is parked; after
//               MAX_WAIT lost cycles the W stage is stalled once to drain it.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int MAX_WAIT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    wb_port_arbiter_if.slave bus
);

    localparam int                 WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);

    arb_state_t            state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic                  pipe_req;
    logic                  mdu_req;
    logic                  buf_load;
    logic                  buf_clear;
    logic                  pend_valid;
    logic [REG_ADDR_W-1:0] pend_rd;
    logic [XLEN-1:0]       pend_data;

    logic                  rf_we_c;
    logic [REG_ADDR_W-1:0] rf_a3_c;
    logic [XLEN-1:0]       rf_wd_c;
    logic                  stallw_c;
    logic                  mdu_ready_c;

    wb_pend_buf #(
        .XLEN (XLEN)
    ) u_pend_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_rd   (bus.mdu_rd),
        .load_data (bus.mdu_result),
        .valid     (pend_valid),
        .rd        (pend_rd),
        .data      (pend_data)
    );

    // x0 is never a real write, so rd==0 does not count as a request
    assign pipe_req = bus.regwritew && (bus.rdw != '0);
    assign mdu_req  = bus.mdu_valid && (bus.mdu_rd != '0);

    // Port grant, buffer control and next-state selection
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        rf_we_c     = 1'b0;
        rf_a3_c     = '0;
        rf_wd_c     = '0;
        stallw_c    = 1'b0;
        mdu_ready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                mdu_ready_c = 1'b1;
                if (pipe_req) begin
                    rf_we_c = 1'b1;
                    rf_a3_c = bus.rdw;
                    rf_wd_c = bus.resultw;
                    if (mdu_req) begin
                        buf_load   = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = HELD;
                    end
                end else if (mdu_req) begin
                    rf_we_c = 1'b1;
                    rf_a3_c = bus.mdu_rd;
                    rf_wd_c = bus.mdu_result;
                end
            end

            HELD: begin
                rf_we_c = 1'b1;
                if (!pipe_req) begin
                    rf_a3_c   = pend_rd;
                    rf_wd_c   = pend_data;
                    buf_clear = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rf_a3_c = bus.rdw;
                    rf_wd_c = bus.resultw;
                    if (bus.rdw == pend_rd) begin
                        // Younger write to the same register supersedes the parked one
                        buf_clear = 1'b1;
                        state_d   = IDLE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = FORCE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end
            end

            FORCE: begin
                stallw_c  = 1'b1;
                rf_we_c   = 1'b1;
                rf_a3_c   = pend_rd;
                rf_wd_c   = pend_data;
                buf_clear = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                buf_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // FSM state and wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are forced low for the whole time reset is held
    assign bus.rf_we      = reset_n & rf_we_c;
    assign bus.rf_a3      = reset_n ? rf_a3_c : '0;
    assign bus.rf_wd      = reset_n ? rf_wd_c : '0;
    assign bus.stallw     = reset_n & stallw_c;
    assign bus.mdu_ready  = reset_n & mdu_ready_c;
    assign bus.pend_valid = pend_valid;
    assign bus.pend_rd    = pend_rd;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               followed by random traffic, all compared every cycle against
//               a behavioural model of the parked result and its age.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    wb_port_arbiter_if #(.XLEN(XLEN)) bus();

    wb_port_arbiter #(
        .XLEN     (XLEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: the parked result (if any) and how many cycles it has lost so far
    logic        m_pv;
    logic [4:0]  m_prd;
    logic [31:0] m_pdata;
    int          m_losses;
    logic        n_pv;
    logic [4:0]  n_prd;
    logic [31:0] n_pdata;
    int          n_losses;
    // Expected port values for the current cycle
    logic        e_we, e_stall, e_ready;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pv     = 1'b0;
        m_prd    = '0;
        m_pdata  = '0;
        m_losses = 0;
    endtask

    task automatic set_in(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
        bus.regwritew  = rw;
        bus.rdw        = rd;
        bus.resultw    = res;
        bus.mdu_valid  = mv;
        bus.mdu_rd     = mrd;
        bus.mdu_result = mres;
    endtask

    // Expected behaviour from the arbitration rules for the present inputs
    task automatic predict();
        logic preq;
        logic mreq;
        preq     = bus.regwritew && (bus.rdw != 5'd0);
        mreq     = bus.mdu_valid && (bus.mdu_rd != 5'd0);
        e_we     = 1'b0; e_a3 = '0; e_wd = '0; e_stall = 1'b0; e_ready = 1'b0;
        n_pv     = m_pv; n_prd = m_prd; n_pdata = m_pdata; n_losses = m_losses;
        if (!m_pv) begin
            e_ready = 1'b1;
            if (preq) begin
                e_we = 1'b1; e_a3 = bus.rdw; e_wd = bus.resultw;
                if (mreq) begin
                    n_pv = 1'b1; n_prd = bus.mdu_rd; n_pdata = bus.mdu_result; n_losses = 0;
                end
            end else if (mreq) begin
                e_we = 1'b1; e_a3 = bus.mdu_rd; e_wd = bus.mdu_result;
            end
        end else if (m_losses >= MAX_WAIT) begin
            e_stall = 1'b1;
            e_we = 1'b1; e_a3 = m_prd; e_wd = m_pdata;
            n_pv = 1'b0; n_prd = '0; n_pdata = '0;
        end else if (!preq) begin
            e_we = 1'b1; e_a3 = m_prd; e_wd = m_pdata;
            n_pv = 1'b0; n_prd = '0; n_pdata = '0;
        end else begin
            e_we = 1'b1; e_a3 = bus.rdw; e_wd = bus.resultw;
            if (bus.rdw == m_prd) begin
                n_pv = 1'b0; n_prd = '0; n_pdata = '0;
            end else begin
                n_losses = m_losses + 1;
            end
        end
        if (!reset_n) begin
            e_we = 1'b0; e_a3 = '0; e_wd = '0; e_stall = 1'b0; e_ready = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        predict();
        chk({tag, ".rf_we"},      64'(bus.rf_we),      64'(e_we));
        chk({tag, ".rf_a3"},      64'(bus.rf_a3),      64'(e_a3));
        chk({tag, ".rf_wd"},      64'(bus.rf_wd),      64'(e_wd));
        chk({tag, ".stallw"},     64'(bus.stallw),     64'(e_stall));
        chk({tag, ".mdu_ready"},  64'(bus.mdu_ready),  64'(e_ready));
        chk({tag, ".pend_valid"}, 64'(bus.pend_valid), 64'(m_pv));
        chk({tag, ".pend_rd"},    64'(bus.pend_rd),    64'(m_pv ? m_prd : 5'd0));
    endtask

    task automatic step_now(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                            input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                            input string tag);
        set_in(rw, rd, res, mv, mrd, mres);
        #1;
        check_outputs(tag);
        m_pv = n_pv; m_prd = n_prd; m_pdata = n_pdata; m_losses = n_losses;
    endtask

    task automatic step(input logic rw, input logic [4:0] rd, input logic [31:0] res,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mres,
                        input string tag);
        @(negedge clk);
        step_now(rw, rd, res, mv, mrd, mres, tag);
    endtask

    initial begin
        model_reset();
        // Active requests during reset must not reach any output
        set_in(1'b1, 5'd3, 32'h1111, 1'b1, 5'd7, 32'h2222);
        #2;
        check_outputs("reset");

        // Release, then park on the very first edge: pipeline rd=3 beats MDU rd=9
        @(negedge clk);
        reset_n = 1'b1;
        step_now(1'b1, 5'd3, 32'h0333, 1'b1, 5'd9, 32'h00AA, "park");
        chk("park.a3_const", 64'(bus.rf_a3), 64'd3);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "drain");
        chk("drain.a3_const", 64'(bus.rf_a3), 64'd9);
        chk("drain.wd_const", 64'(bus.rf_wd), 64'h00AA);

        // Bypass in IDLE, then confirm nothing was parked
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, "bypass");
        chk("bypass.wd_const", 64'(bus.rf_wd), 64'h1234);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "bypass_after");

        // Forced stall: park rd=9, lose MAX_WAIT times, then one stall cycle
        step(1'b1, 5'd3, 32'h0003, 1'b1, 5'd9, 32'h0099, "fs_park");
        for (int i = 0; i < MAX_WAIT; i++)
            step(1'b1, 5'd4, 32'h4000 + i, 1'b1, 5'd11, 32'hDEAD, "fs_lose");
        step(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, "fs_stall");
        chk("fs_stall.stall_const", 64'(bus.stallw), 64'd1);
        chk("fs_stall.a3_const",    64'(bus.rf_a3),  64'd9);
        step(1'b1, 5'd4, 32'h4444, 1'b0, 5'd0, 32'h0, "fs_resume");
        chk("fs_resume.stall_const", 64'(bus.stallw), 64'd0);

        // WAW: the pipeline overwrites the parked register, parked value is dropped
        step(1'b1, 5'd2, 32'h0002, 1'b1, 5'd5, 32'h0055, "waw_park");
        step(1'b1, 5'd5, 32'h0077, 1'b0, 5'd0, 32'h0, "waw_hit");
        chk("waw_hit.wd_const", 64'(bus.rf_wd), 64'h0077);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "waw_after");
        chk("waw_after.we_const", 64'(bus.rf_we), 64'd0);

        // x0: MDU rd=0 is discarded; pipeline rd=0 lets a parked result drain
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBEEF, "x0_mdu");
        step(1'b1, 5'd1, 32'h0001, 1'b1, 5'd6, 32'h0066, "x0_park");
        step(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, "x0_pipe");
        chk("x0_pipe.a3_const", 64'(bus.rf_a3), 64'd6);

        // Random traffic over a small register range to provoke WAW and aging
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, "rand");
        end
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "rand_flush");
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "rand_flush");

        // Reset asserted in the middle of a FORCE cycle
        step(1'b1, 5'd3, 32'h0003, 1'b1, 5'd9, 32'h0099, "rf_park");
        for (int i = 0; i < MAX_WAIT; i++)
            step(1'b1, 5'd4, 32'h5000 + i, 1'b0, 5'd0, 32'h0, "rf_lose");
        @(negedge clk);
        set_in(1'b1, 5'd4, 32'h5555, 1'b1, 5'd12, 32'hCAFE);
        #1;
        check_outputs("rf_force");
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rf_in_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step_now(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, "rf_after");
        chk("rf_after.ready_const", 64'(bus.mdu_ready),  64'd1);
        chk("rf_after.pv_const",    64'(bus.pend_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
